gpr_register_file: RTL and testbench
====================================

Name: gpr_register_file

Overview:
- General-purpose register file that sits directly downstream of the instruction decoder.
- Provides three registered read ports (A, B, C) addressed by the decoder's read-address outputs.
- Provides two write ports:
  - X: LOAD data, taken from the word on the memory read bus one cycle after the LOAD instruction.
  - Y: multiply/add results, two cycles after decode.
- Detects and flags same-cycle write-port collisions.

Parameters:
- DATA_W, 32, width of each GPR and of every data port.
- ADDR_W, 4, width of every register address.
- NUM_REGS, 16, number of GPRs; must equal 2**ADDR_W.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RdAdrA  input  ADDR_W  read address, port A.
- RdAdrB  input  ADDR_W  read address, port B.
- RdAdrC  input  ADDR_W  read address, port C.
- RdDataA  output  DATA_W  registered read data, port A.
- RdDataB  output  DATA_W  registered read data, port B.
- RdDataC  output  DATA_W  registered read data, port C.
- WrtAdrX  input  ADDR_W  write address, port X (LOAD).
- WrtEnbX  input  1  write enable, port X.
- WrtDataX  input  DATA_W  write data, port X (memory read bus word).
- WrtAdrY  input  ADDR_W  write address, port Y (arithmetic result).
- WrtEnbY  input  1  write enable, port Y.
- WrtDataY  input  DATA_W  write data, port Y.
- ClrCollision  input  1  clears the sticky collision flag.
- WrtCollision  output  1  sticky flag: X and Y wrote the same address in the same cycle.
- WrtCount  output  16  count of committed register writes, saturating.

Behaviour:
- Reset is decided as: reset is synchronous and active-high; the clock is clock.
- Reset values:
  - All NUM_REGS registers = 0.
  - RdDataA/B/C = 0, WrtCollision = 0, WrtCount = 0.
- Reset takes priority over every write and read in the same cycle; any write presented during reset is discarded.
- Register 0 is an ordinary writable register; it is not hardwired to zero.
- Writes:
  - On a rising edge with reset low, reg[WrtAdrX] <= WrtDataX if WrtEnbX.
  - On a rising edge with reset low, reg[WrtAdrY] <= WrtDataY if WrtEnbY.
  - Both ports may write different addresses in the same cycle; both commit.
- Collision, defined as WrtEnbX && WrtEnbY && WrtAdrX == WrtAdrY:
  - Port Y wins; the X data is dropped.
  - WrtCollision goes to 1 at that edge and stays set.
  - ClrCollision=1 clears WrtCollision at the next edge.
  - A new collision in the same cycle as ClrCollision leaves WrtCollision = 1 (set wins).
- Reads:
  - Latency is 1 cycle.
  - At edge n, RdDataK <= value of reg[RdAdrK] as sampled at edge n, for K in A, B, C.
  - The value returned is the pre-write value unless the bypass option is enabled (see Optional Feature).
  - All three ports may address the same register.
- WrtCount:
  - Adds 0, 1 or 2 per cycle: one per committed write, so a collision counts as 1.
  - Saturates at 16'hFFFF with no wrap-around.
  - Cleared only by reset.
- No internal state machine beyond the register array, the read output registers, the flag and the counter.
- No combinational path from any input to any output.

Optional Feature:
- Macro: GPR_WRITE_BYPASS_EN.
- Defined:
  - A read whose address matches an active same-cycle write returns the new data.
  - If both ports match, Y data is returned (matches the collision winner).
  - Each read port has independent compare logic.
- Undefined:
  - Same-cycle read-after-write returns the old contents.
  - The new value is visible one cycle later.
- The macro does not affect write, collision or counter behaviour.

Test Plan:
1. Reset, then read all 16 addresses on A/B/C -> every RdData = 0, WrtCollision = 0, WrtCount = 0.
2. Write X addr 3 = 32'h12345678 and Y addr 5 = 32'hCAFEF00D in the same cycle; next cycle read A=3, B=5, C=3 -> after 1 cycle A = 32'h12345678, B = 32'hCAFEF00D, C = 32'h12345678; WrtCount = 2.
3. Collision: X and Y both write addr 7 (X = 32'h1, Y = 32'h2) -> reg7 = 32'h2; WrtCollision = 1 next cycle and stays 1; WrtCount += 1. Assert ClrCollision -> flag = 0. Assert ClrCollision together with a new collision -> flag stays 1.
4. Same-cycle read and write to addr 9 (old value 32'hAAAA0000, new 32'hBBBB0000):
   - Without the macro, RdData = 32'hAAAA0000.
   - With GPR_WRITE_BYPASS_EN, RdData = 32'hBBBB0000.
   - The read on the following cycle returns 32'hBBBB0000 in both builds.
5. Assert reset together with WrtEnbX to addr 2 = 32'hFFFFFFFF -> reg2 stays 0; the read on the next cycle returns 0.
6. Preload WrtCount to 16'hFFFE by issuing double writes -> further writes hold the count at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/gpr_register_file.sv
// Decoder-side GPR file: 3 registered read ports, X (load) and Y (arith) write ports; Y wins collisions.
// Read latency 1 cycle, no backpressure; GPR_WRITE_BYPASS_EN forwards same-cycle write data to reads.
module gpr_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RdAdrA,
  input  logic [ADDR_W-1:0] RdAdrB,
  input  logic [ADDR_W-1:0] RdAdrC,
  output logic [DATA_W-1:0] RdDataA,
  output logic [DATA_W-1:0] RdDataB,
  output logic [DATA_W-1:0] RdDataC,
  input  logic [ADDR_W-1:0] WrtAdrX,
  input  logic              WrtEnbX,
  input  logic [DATA_W-1:0] WrtDataX,
  input  logic [ADDR_W-1:0] WrtAdrY,
  input  logic              WrtEnbY,
  input  logic [DATA_W-1:0] WrtDataY,
  input  logic              ClrCollision,
  output logic              WrtCollision,
  output logic [15:0]       WrtCount
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] rdAdr [3];
  logic [DATA_W-1:0] rdNext [3];
  logic              collision;
  logic              commitX;
  logic [1:0]        wrInc;
  logic [16:0]       cntSum;

  assign rdAdr[0] = RdAdrA;
  assign rdAdr[1] = RdAdrB;
  assign rdAdr[2] = RdAdrC;

  assign collision = WrtEnbX && WrtEnbY && (WrtAdrX == WrtAdrY);
  // X is suppressed on a collision so Y's data is the one that lands.
  assign commitX   = WrtEnbX && !collision;
  assign wrInc     = {1'b0, commitX} + {1'b0, WrtEnbY};
  assign cntSum    = {1'b0, WrtCount} + {15'b0, wrInc};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rdNext[k] = regs[rdAdr[k]];
`ifdef GPR_WRITE_BYPASS_EN
      // Y is checked last so it overrides X, mirroring the collision winner.
      if (WrtEnbX && (WrtAdrX == rdAdr[k])) rdNext[k] = WrtDataX;
      if (WrtEnbY && (WrtAdrY == rdAdr[k])) rdNext[k] = WrtDataY;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (commitX) regs[WrtAdrX] <= WrtDataX;
      if (WrtEnbY) regs[WrtAdrY] <= WrtDataY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      RdDataA <= '0;
      RdDataB <= '0;
      RdDataC <= '0;
    end else begin
      RdDataA <= rdNext[0];
      RdDataB <= rdNext[1];
      RdDataC <= rdNext[2];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      WrtCollision <= 1'b0;
      WrtCount     <= '0;
    end else begin
      if (collision)         WrtCollision <= 1'b1;
      else if (ClrCollision) WrtCollision <= 1'b0;
      WrtCount <= cntSum[16] ? 16'hFFFF : cntSum[15:0];
    end
  end

endmodule

// File: tb/tb_gpr_register_file.sv
// Directed self-checking bench for gpr_register_file; expectations honour GPR_WRITE_BYPASS_EN if defined.
module tb_gpr_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  RdAdrA, RdAdrB, RdAdrC;
  logic [31:0] RdDataA, RdDataB, RdDataC;
  logic [3:0]  WrtAdrX, WrtAdrY;
  logic        WrtEnbX, WrtEnbY;
  logic [31:0] WrtDataX, WrtDataY;
  logic        ClrCollision;
  logic        WrtCollision;
  logic [15:0] WrtCount;

  int checks   = 0;
  int failures = 0;

  gpr_register_file #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(16)) dut (
    .clock(clock), .reset(reset),
    .RdAdrA(RdAdrA), .RdAdrB(RdAdrB), .RdAdrC(RdAdrC),
    .RdDataA(RdDataA), .RdDataB(RdDataB), .RdDataC(RdDataC),
    .WrtAdrX(WrtAdrX), .WrtEnbX(WrtEnbX), .WrtDataX(WrtDataX),
    .WrtAdrY(WrtAdrY), .WrtEnbY(WrtEnbY), .WrtDataY(WrtDataY),
    .ClrCollision(ClrCollision), .WrtCollision(WrtCollision), .WrtCount(WrtCount)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idleWrites;
    WrtEnbX = 1'b0;
    WrtEnbY = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    RdAdrA = '0; RdAdrB = '0; RdAdrC = '0;
    WrtAdrX = '0; WrtAdrY = '0; WrtEnbX = 1'b0; WrtEnbY = 1'b0;
    WrtDataX = '0; WrtDataY = '0; ClrCollision = 1'b0;
    step;
    step;
    checkValue("rst_rdA", RdDataA, 32'h0);
    checkValue("rst_rdB", RdDataB, 32'h0);
    checkValue("rst_rdC", RdDataC, 32'h0);
    checkValue("rst_coll", {31'b0, WrtCollision}, 32'h0);
    checkValue("rst_cnt", {16'b0, WrtCount}, 32'h0);
    reset = 1'b0;

    // 1: every register reads zero after reset
    for (int i = 0; i < 16; i++) begin
      RdAdrA = 4'(i); RdAdrB = 4'(i); RdAdrC = 4'(i);
      step;
      checkValue("zero_rdA", RdDataA, 32'h0);
      checkValue("zero_rdB", RdDataB, 32'h0);
      checkValue("zero_rdC", RdDataC, 32'h0);
    end
    checkValue("zero_cnt", {16'b0, WrtCount}, 32'h0);

    // 2: two writes to distinct addresses in one cycle
    WrtAdrX = 4'd3; WrtDataX = 32'h12345678; WrtEnbX = 1'b1;
    WrtAdrY = 4'd5; WrtDataY = 32'hCAFEF00D; WrtEnbY = 1'b1;
    step;
    idleWrites;
    RdAdrA = 4'd3; RdAdrB = 4'd5; RdAdrC = 4'd3;
    step;
    checkValue("dual_rdA", RdDataA, 32'h12345678);
    checkValue("dual_rdB", RdDataB, 32'hCAFEF00D);
    checkValue("dual_rdC", RdDataC, 32'h12345678);
    checkValue("dual_cnt", {16'b0, WrtCount}, 32'd2);
    checkValue("dual_coll", {31'b0, WrtCollision}, 32'h0);

    // 3: collision on addr 7, Y wins, sticky flag, clear, set-beats-clear
    WrtAdrX = 4'd7; WrtDataX = 32'h1; WrtEnbX = 1'b1;
    WrtAdrY = 4'd7; WrtDataY = 32'h2; WrtEnbY = 1'b1;
    step;
    idleWrites;
    checkValue("coll_set", {31'b0, WrtCollision}, 32'h1);
    checkValue("coll_cnt", {16'b0, WrtCount}, 32'd3);
    RdAdrA = 4'd7;
    step;
    checkValue("coll_reg7", RdDataA, 32'h2);
    checkValue("coll_sticky", {31'b0, WrtCollision}, 32'h1);
    ClrCollision = 1'b1;
    step;
    ClrCollision = 1'b0;
    checkValue("coll_clr", {31'b0, WrtCollision}, 32'h0);
    ClrCollision = 1'b1;
    WrtAdrX = 4'd7; WrtDataX = 32'h3; WrtEnbX = 1'b1;
    WrtAdrY = 4'd7; WrtDataY = 32'h4; WrtEnbY = 1'b1;
    step;
    ClrCollision = 1'b0;
    idleWrites;
    checkValue("coll_setwins", {31'b0, WrtCollision}, 32'h1);
    checkValue("coll_cnt2", {16'b0, WrtCount}, 32'd4);
    step;
    checkValue("coll_reg7b", RdDataA, 32'h4);

    // 4: same-cycle read and write of addr 9
    WrtAdrX = 4'd9; WrtDataX = 32'hAAAA0000; WrtEnbX = 1'b1;
    step;
    idleWrites;
    WrtAdrY = 4'd9; WrtDataY = 32'hBBBB0000; WrtEnbY = 1'b1;
    RdAdrA = 4'd9;
    step;
    idleWrites;
`ifdef GPR_WRITE_BYPASS_EN
    checkValue("raw_same", RdDataA, 32'hBBBB0000);
`else
    checkValue("raw_same", RdDataA, 32'hAAAA0000);
`endif
    step;
    checkValue("raw_next", RdDataA, 32'hBBBB0000);
    checkValue("raw_cnt", {16'b0, WrtCount}, 32'd6);

    // 5: write during reset is discarded
    reset = 1'b1;
    WrtAdrX = 4'd2; WrtDataX = 32'hFFFFFFFF; WrtEnbX = 1'b1;
    step;
    reset = 1'b0;
    idleWrites;
    RdAdrA = 4'd2; RdAdrB = 4'd7;
    step;
    checkValue("rstwr_reg2", RdDataA, 32'h0);
    checkValue("rstwr_reg7", RdDataB, 32'h0);
    checkValue("rstwr_cnt", {16'b0, WrtCount}, 32'h0);
    checkValue("rstwr_coll", {31'b0, WrtCollision}, 32'h0);

    // 6: counter saturation, also exercising register 0 as writable
    WrtAdrX = 4'd0; WrtDataX = 32'h00000A0A; WrtEnbX = 1'b1;
    WrtAdrY = 4'd1; WrtDataY = 32'h00000B0B; WrtEnbY = 1'b1;
    for (int i = 0; i < 32767; i++) step;
    checkValue("sat_pre", {16'b0, WrtCount}, 32'h0000FFFE);
    step;
    checkValue("sat_double", {16'b0, WrtCount}, 32'h0000FFFF);
    WrtEnbY = 1'b0;
    step;
    checkValue("sat_single", {16'b0, WrtCount}, 32'h0000FFFF);
    WrtAdrY = 4'd0; WrtEnbY = 1'b1;
    step;
    idleWrites;
    checkValue("sat_coll", {16'b0, WrtCount}, 32'h0000FFFF);
    RdAdrA = 4'd0; RdAdrB = 4'd1;
    step;
    checkValue("reg0_wr", RdDataA, 32'h00000B0B);
    checkValue("reg1_wr", RdDataB, 32'h00000B0B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
